// File: rtl/gate_test_pkg.sv
// rtl/gate_test_pkg.sv - shared LED map and gate function for the gate demonstrator
package gate_test_pkg;

  localparam int NUM_GATES = 5;

  localparam int LED_AND  = 0;
  localparam int LED_OR   = 1;
  localparam int LED_NAND = 2;
  localparam int LED_NOR  = 3;
  localparam int LED_XOR  = 4;

  typedef logic [NUM_GATES-1:0] gate_vec_t;

  // One bit per basic gate, placed at its LED index
  function automatic gate_vec_t gate_vec(input logic a, input logic b);
    gate_vec_t v;
    v           = '0;
    v[LED_AND]  = a & b;
    v[LED_OR]   = a | b;
    v[LED_NAND] = ~(a & b);
    v[LED_NOR]  = ~(a | b);
    v[LED_XOR]  = a ^ b;
    return v;
  endfunction

endpackage

// File: rtl/gate_test_sync_bit.sv
// rtl/gate_test_sync_bit.sv - single-bit flop-chain synchronizer with synchronous clear
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw input through the chain; reset flushes anything in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/gate_test.sv
// rtl/gate_test.sv - two-input gate demonstrator driving five registered LEDs
module gate_test
  import gate_test_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a,
  input  logic                 b,
  output logic [NUM_GATES-1:0] led
);

  logic sa;
  logic sb;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_a (
    .clk   (clk),
    .reset (reset),
    .d     (a),
    .q     (sa)
  );

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_b (
    .clk   (clk),
    .reset (reset),
    .d     (b),
    .q     (sb)
  );

  // Register the gate vector of the synchronized operands every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      led <= '0;
    end else begin
      led <= gate_vec(sa, sb);
    end
  end

`ifndef SYNTHESIS
  localparam logic [3:0] SETTLE = 4'(SYNC_STAGES + 1);

  logic [3:0] run_cnt;

  // Count consecutive non-reset edges so the latency check only fires on a filled pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt <= '0;
    end else if (run_cnt != 4'hf) begin
      run_cnt <= run_cnt + 4'd1;
    end
  end

  latency_check: assert property (@(posedge clk)
    (run_cnt >= SETTLE) |->
      (led == gate_vec($past(a, SYNC_STAGES + 1), $past(b, SYNC_STAGES + 1))));
`endif

endmodule

// File: tb/tb_gate_test.sv
// tb/tb_gate_test.sv - self-checking bench for gate_test with a history-based reference model
module tb_gate_test;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       a;
  logic       b;
  logic [4:0] led;

  int errors = 0;
  int checks = 0;
  int tick_no = 0;

  logic       hist_a[$];
  logic       hist_b[$];
  logic       hist_r[$];
  logic [4:0] exp_led;

  gate_test #(.SYNC_STAGES(S)) dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .led   (led)
  );

  always #5 clk = ~clk;

  // Truth of each gate from the count of high inputs; bit order AND, OR, NAND, NOR, XOR
  function automatic logic [4:0] ref_gates(input logic x, input logic y);
    int n;
    logic [4:0] r;
    n    = int'(x) + int'(y);
    r[0] = (n == 2);
    r[1] = (n >= 1);
    r[2] = (n < 2);
    r[3] = (n == 0);
    r[4] = (n == 1);
    return r;
  endfunction

  // Reference: led after an edge reflects inputs seen S edges earlier, unless a reset
  // fell on this edge (all zero) or inside the window (inputs lost, treated as zero)
  always @(posedge clk) begin
    logic clean;
    hist_a.push_front(a);
    hist_b.push_front(b);
    hist_r.push_front(reset);
    while (hist_a.size() > S + 1) begin
      void'(hist_a.pop_back());
      void'(hist_b.pop_back());
      void'(hist_r.pop_back());
    end
    if (hist_r[0]) begin
      exp_led = 5'b00000;
    end else begin
      clean = 1'b1;
      for (int i = 1; i <= S; i++) if (hist_r[i]) clean = 1'b0;
      exp_led = clean ? ref_gates(hist_a[S], hist_b[S]) : ref_gates(1'b0, 1'b0);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    tick_no++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a     = 1'b0;
    b     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (led !== 5'b00000) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: led=%b expected 00000", i, led);
      end
    end
    reset = 1'b0;
    tick();
    checks++;
    if (led !== 5'b01100) begin
      errors++;
      $display("FAIL reset_release: led=%b expected 01100", led);
    end
  endtask

  task automatic test_patterns();
    logic       pa[3]   = '{1'b0, 1'b1, 1'b1};
    logic       pb[3]   = '{1'b1, 1'b0, 1'b1};
    logic [4:0] pexp[3] = '{5'b10110, 5'b10110, 5'b00011};
    for (int p = 0; p < 3; p++) begin
      a = pa[p];
      b = pb[p];
      for (int c = 0; c < S + 1; c++) tick();
      checks++;
      if (led !== pexp[p]) begin
        errors++;
        $display("FAIL pattern a=%b b=%b: led=%b expected %b", pa[p], pb[p], led, pexp[p]);
      end
    end
  endtask

  task automatic test_sweep();
    logic sa_v[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic sb_v[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int   change_t[4];
    a = 1'b0;
    b = 1'b0;
    for (int c = 0; c < S + 2; c++) tick();
    change_t[0] = tick_no - (S + 2);
    for (int step = 1; step < 4 + 2; step++) begin
      if (step < 4) begin
        a = sa_v[step];
        b = sb_v[step];
        change_t[step] = tick_no;
      end
      for (int c = 0; c < 2; c++) begin
        tick();
        checks++;
        if ($isunknown(led)) begin
          errors++;
          $display("FAIL sweep_no_x tick %0d: led=%b expected known value", tick_no, led);
        end
        checks++;
        if (led !== exp_led) begin
          errors++;
          $display("FAIL sweep_model tick %0d: led=%b expected %b", tick_no, led, exp_led);
        end
        for (int i = 1; i < 4; i++) begin
          if (tick_no == change_t[i] + S + 1) begin
            checks++;
            if (led !== ref_gates(sa_v[i], sb_v[i])) begin
              errors++;
              $display("FAIL sweep_land step %0d: led=%b expected %b", i, led,
                       ref_gates(sa_v[i], sb_v[i]));
            end
          end
          if (tick_no == change_t[i] + S &&
              ref_gates(sa_v[i], sb_v[i]) != ref_gates(sa_v[i-1], sb_v[i-1])) begin
            checks++;
            if (led === ref_gates(sa_v[i], sb_v[i])) begin
              errors++;
              $display("FAIL sweep_early step %0d: led=%b expected %b", i, led,
                       ref_gates(sa_v[i-1], sb_v[i-1]));
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset_midop();
    a = 1'b1;
    b = 1'b1;
    for (int c = 0; c < S + 2; c++) tick();
    checks++;
    if (led !== 5'b00011) begin
      errors++;
      $display("FAIL midop_before: led=%b expected 00011", led);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (led !== 5'b00000) begin
      errors++;
      $display("FAIL midop_reset: led=%b expected 00000", led);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (led !== 5'b01100) begin
      errors++;
      $display("FAIL midop_release_e1: led=%b expected 01100", led);
    end
    tick();
    checks++;
    if (led !== 5'b01100 && led !== 5'b00011) begin
      errors++;
      $display("FAIL midop_release_e2: led=%b expected 01100 or 00011", led);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (led !== 5'b00011) begin
        errors++;
        $display("FAIL midop_release_e%0d: led=%b expected 00011", c + 3, led);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    for (int n = 0; n < 120; n++) begin
      a     = 1'($urandom_range(0, 1));
      b     = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 19) == 0);
      hold  = $urandom_range(1, 3);
      for (int c = 0; c < hold; c++) begin
        tick();
        checks++;
        if (led !== exp_led) begin
          errors++;
          $display("FAIL random tick %0d: led=%b expected %b", tick_no, led, exp_led);
        end
      end
      reset = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    a     = 1'b0;
    b     = 1'b0;
    for (int i = 0; i <= S; i++) begin
      hist_a.push_front(1'b0);
      hist_b.push_front(1'b0);
      hist_r.push_front(1'b1);
    end
    test_reset();
    test_patterns();
    test_sweep();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
